// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the iterative multiplier:
//   mul_opcode_e  - MUL (low half), MULH (high half), MAC (low half + addend)
//   mult_state_e  - control FSM states of riscv_mult_iter
//   is_high_half  - helper: opcode selects the upper XLEN bits of the product
// ----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        MULH = 2'd1,
        MAC  = 2'd2
    } mul_opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mult_state_e;

    function automatic logic is_high_half(input mul_opcode_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/riscv_mult_iter_if.sv
// ----------------------------------------------------------------------------
// riscv_mult_iter_if
// Request/result bundle of the iterative multiplier.
//   Request : enable_i, operator_i, short_signed_i, operand_a/b/c_i
//   Result  : ex_ready_i (consumer), result_o, valid_o
//   Status  : ready_o, multicycle_o, mulh_active_o
// Modports: master = requester/consumer, slave = multiplier.
// ----------------------------------------------------------------------------
interface riscv_mult_iter_if #(
    parameter int XLEN = 32
) ();
    import riscv_pkg::*;

    logic              enable_i;
    mul_opcode_e       operator_i;
    logic [1:0]        short_signed_i;
    logic [XLEN-1:0]   operand_a_i;
    logic [XLEN-1:0]   operand_b_i;
    logic [XLEN-1:0]   operand_c_i;
    logic              ex_ready_i;
    logic [XLEN-1:0]   result_o;
    logic              valid_o;
    logic              ready_o;
    logic              multicycle_o;
    logic              mulh_active_o;

    modport master (
        output enable_i, operator_i, short_signed_i,
        output operand_a_i, operand_b_i, operand_c_i, ex_ready_i,
        input  result_o, valid_o, ready_o, multicycle_o, mulh_active_o
    );

    modport slave (
        input  enable_i, operator_i, short_signed_i,
        input  operand_a_i, operand_b_i, operand_c_i, ex_ready_i,
        output result_o, valid_o, ready_o, multicycle_o, mulh_active_o
    );

endinterface

// File: rtl/riscv_mult_step.sv
// ----------------------------------------------------------------------------
// riscv_mult_step
// Combinational radix-2^STEP step of a shift-add multiplier.
//   acc_i    [2*XLEN] running accumulator (upper half holds the partial sum)
//   a_i      [XLEN]   multiplicand magnitude
//   b_bits_i [STEP]   next STEP multiplier bits (LSB first)
//   acc_o    [2*XLEN] accumulator after adding a_i*b_bits_i into the upper
//                     half and shifting right by STEP
// ----------------------------------------------------------------------------
module riscv_mult_step #(
    parameter int XLEN = 32,
    parameter int STEP = 2
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [STEP-1:0]   b_bits_i,
    output logic [2*XLEN-1:0] acc_o
);
    // Upper-half sum never exceeds (2^XLEN-1)*2^STEP, so XLEN+STEP bits hold it.
    localparam int SW = XLEN + STEP;

    logic [STEP-1:0][SW-1:0] pp;
    logic [SW-1:0]           sum;
    logic [2*XLEN+STEP-1:0]  wide;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
            assign pp[gi] = b_bits_i[gi] ? (SW'(a_i) << gi) : '0;
        end
    endgenerate

    always_comb begin
        sum = SW'(acc_i[2*XLEN-1:XLEN]);
        for (int i = 0; i < STEP; i++) begin
            sum = sum + pp[i];
        end
    end

    assign wide  = {sum, acc_i[XLEN-1:0]};
    assign acc_o = wide[2*XLEN+STEP-1:STEP];

endmodule

// File: rtl/riscv_mult_iter.sv
// ----------------------------------------------------------------------------
// riscv_mult_iter
// Iterative sign/magnitude multiplier retiring STEP product bits per cycle.
// Operands are captured on acceptance (IDLE & enable_i), multiplied as
// unsigned magnitudes over XLEN/STEP CALC cycles, then sign-corrected and
// half-selected on entry to DONE, where the result is held until ex_ready_i.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : request, result and status signals (riscv_mult_iter_if)
// Optional feature: define RISCV_MULT_MAC_EN to make MAC add operand_c_i to
// the low half; otherwise MAC behaves as MUL and operand_c_i is unused.
// ----------------------------------------------------------------------------
module riscv_mult_iter
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    riscv_mult_iter_if.slave  bus
);
    localparam int NSTEPS = XLEN / STEP;
    localparam int CNT_W  = $clog2(NSTEPS + 1);
    localparam int PW     = 2 * XLEN;

    mult_state_e       state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [PW-1:0]     acc_q,    acc_d;
    logic [XLEN-1:0]   a_mag_q,  a_mag_d;
    logic [XLEN-1:0]   b_mag_q,  b_mag_d;
    logic              neg_q,    neg_d;
    mul_opcode_e       op_q,     op_d;
    logic [XLEN-1:0]   result_q, result_d;
`ifdef RISCV_MULT_MAC_EN
    logic [XLEN-1:0]   c_q,      c_d;
`endif

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [PW-1:0]     acc_step;
    logic [PW-1:0]     prod_signed;
    logic [XLEN-1:0]   low_half;
    logic [XLEN-1:0]   fin_result;

    // A most-negative operand negates to 2^(XLEN-1), which still fits unsigned.
    assign sign_a = bus.short_signed_i[0] & bus.operand_a_i[XLEN-1];
    assign sign_b = bus.short_signed_i[1] & bus.operand_b_i[XLEN-1];
    assign mag_a  = sign_a ? (~bus.operand_a_i + XLEN'(1)) : bus.operand_a_i;
    assign mag_b  = sign_b ? (~bus.operand_b_i + XLEN'(1)) : bus.operand_b_i;

    riscv_mult_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .acc_i    (acc_q),
        .a_i      (a_mag_q),
        .b_bits_i (b_mag_q[STEP-1:0]),
        .acc_o    (acc_step)
    );

    // Final result is formed from the last step's output so it can be
    // registered on the same edge that enters DONE.
    assign prod_signed = neg_q ? (~acc_step + PW'(1)) : acc_step;

    always_comb begin
        low_half = prod_signed[XLEN-1:0];
`ifdef RISCV_MULT_MAC_EN
        if (op_q == MAC) begin
            low_half = prod_signed[XLEN-1:0] + c_q;
        end
`endif
        fin_result = is_high_half(op_q) ? prod_signed[PW-1:XLEN] : low_half;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;
`ifdef RISCV_MULT_MAC_EN
        c_d      = c_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.enable_i) begin
                    a_mag_d = mag_a;
                    b_mag_d = mag_b;
                    neg_d   = sign_a ^ sign_b;
                    op_d    = bus.operator_i;
`ifdef RISCV_MULT_MAC_EN
                    c_d     = bus.operand_c_i;
`endif
                    acc_d   = '0;
                    cnt_d   = CNT_W'(NSTEPS);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d   = acc_step;
                b_mag_d = b_mag_q >> STEP;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = fin_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.ex_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            op_q     <= MUL;
            result_q <= '0;
`ifdef RISCV_MULT_MAC_EN
            c_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
`ifdef RISCV_MULT_MAC_EN
            c_q      <= c_d;
`endif
        end
    end

    assign bus.result_o      = result_q;
    assign bus.valid_o       = (state_q == S_DONE);
    assign bus.ready_o       = (state_q == S_IDLE);
    assign bus.multicycle_o  = (state_q != S_IDLE);
    assign bus.mulh_active_o = (state_q != S_IDLE) && (op_q == MULH);

endmodule
